// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and SPI mode indices ({cpol, cpha}).
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;
endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period divider, SCK edge counter and leading/trailing edge flags.
module spi_clkgen #(
  parameter int DIV_W = 8,
  parameter int DATA_W = 8,
  localparam int EW = $clog2(2 * DATA_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             lead,
  output logic             trail,
  output logic             done,
  output logic [EW-1:0]    edges
);
  logic [DIV_W-1:0] div_l, cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_l <= '0;
      cnt   <= '0;
      edges <= '0;
    end else if (load) begin
      div_l <= div;
      cnt   <= div;
      edges <= '0;
    end else if (run) begin
      cnt <= tick ? div_l : cnt - 1'b1;
      if (step) edges <= edges + 1'b1;
    end
  end
  assign tick  = run && cnt == '0;
  assign lead  = !edges[0];
  assign trail = edges[0];
  assign done  = edges == EW'(2 * DATA_W);
endmodule

// File: rtl/spi_master.sv
// spi_master: SPI master with holding register, runtime divider, CPOL/CPHA modes and CS framing.
module spi_master #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W = 8,
  localparam int CS_W = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] txdata,
  input  logic              txstart,
  output logic              txready,
  output logic [DATA_W-1:0] rxdata,
  output logic              rxvalid,
  output logic              busy,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cs_hold,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);
  import spi_pkg::*;
  localparam int EW = $clog2(2 * DATA_W + 1);
  state_t state, state_d;
  logic hold_full, load, step, samp, last, mshift, ph1;
  logic tick, lead, trail, done;
  logic cpol_l, cpha_l, lsb_l;
  logic [1:0] mode;
  logic [CS_W-1:0] sel_l;
  logic [EW-1:0] edges;
  logic [DATA_W-1:0] hold_data, tsr, tsr_s, rsr, rsr_d;
  logic [NUM_CS-1:0] cs_dec;
  spi_clkgen #(.DIV_W(DIV_W), .DATA_W(DATA_W)) u_clkgen (
    .clk(clk), .rst_n(rst_n), .load(load), .run(state != IDLE), .step(step), .div(div),
    .tick(tick), .lead(lead), .trail(trail), .done(done), .edges(edges)
  );
  // The half-period after a word's last edge doubles as the next word's setup when chaining.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    cs_dec  = '1;
    case (state)
      IDLE: if (hold_full) begin load = 1'b1; state_d = SETUP; end
      SETUP, SHIFT:
        if (tick && !done) begin step = 1'b1; state_d = SHIFT; end
        else if (tick && hold_full && cs_hold && cs_sel == sel_l) load = 1'b1;
        else if (tick) state_d = HOLD;
      HOLD: if (tick) state_d = GAP;
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mode   = {cpol_l, cpha_l};
    ph1    = mode == MODE1 || mode == MODE3;
    samp   = step && (ph1 ? trail : lead);
    last   = samp && edges == (ph1 ? EW'(2 * DATA_W - 1) : EW'(2 * DATA_W - 2));
    mshift = step && (ph1 ? lead : trail) && edges != '0 && edges != EW'(2 * DATA_W - 1);
    rsr_d  = lsb_l ? {spi_miso, rsr[DATA_W-1:1]} : {rsr[DATA_W-2:0], spi_miso};
    tsr_s  = lsb_l ? tsr >> 1 : tsr << 1;
    for (int i = 0; i < NUM_CS; i++) cs_dec[i] = cs_sel != CS_W'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      tsr       <= '0;
      rsr       <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      lsb_l     <= 1'b0;
      sel_l     <= '0;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_cs_n  <= '1;
      rxdata    <= '0;
      rxvalid   <= 1'b0;
    end else begin
      state     <= state_d;
      hold_full <= (txstart && !hold_full) || (hold_full && !load);
      if (txstart && !hold_full) hold_data <= txdata;
      rxvalid   <= last;
      if (samp) rsr <= rsr_d;
      if (last) rxdata <= rsr_d;
      spi_sck   <= state == IDLE ? cpol : (step ? !spi_sck : spi_sck);
      if (load) begin
        cpol_l   <= cpol;
        cpha_l   <= cpha;
        lsb_l    <= lsb_first;
        sel_l    <= cs_sel;
        tsr      <= hold_data;
        spi_mosi <= lsb_first ? hold_data[0] : hold_data[DATA_W-1];
        spi_cs_n <= cs_dec;
      end else begin
        if (mshift) begin
          tsr      <= tsr_s;
          spi_mosi <= lsb_l ? tsr_s[0] : tsr_s[DATA_W-1];
        end
        if (state == HOLD && tick) spi_cs_n <= '1;
      end
    end
  end
  assign txready = !hold_full;
  assign busy    = state != IDLE || hold_full;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of framing, modes, queueing, bit order and reset for spi_master.
module tb_spi_master;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] txdata = '0, div = '0;
  logic txstart = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, cs_hold = 1'b0, loop = 1'b1;
  logic [1:0] cs_sel = '0;
  logic txready, rxvalid, busy, spi_sck, spi_mosi, spi_miso;
  logic [7:0] rxdata;
  logic [2:0] spi_cs_n;
  int checks = 0, failures = 0;
  int rv_cnt = 0, cs0_cnt = 0, cs_any_cnt = 0, busy_cnt = 0, cs_falls = 0;
  int sl_e = 0;
  logic [7:0] rx_q[$];
  logic [7:0] mosi_cap = '0, sl_word = 8'h3C;
  logic prev_cs0 = 1'b1, sl_sck = 1'b0, sl_bit = 1'b0;

  spi_master #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .txdata(txdata), .txstart(txstart), .txready(txready),
    .rxdata(rxdata), .rxvalid(rxvalid), .busy(busy), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .div(div), .cs_sel(cs_sel), .cs_hold(cs_hold),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;
  assign spi_miso = loop ? spi_mosi : sl_bit;

  // Slave on CS0 shifts out sl_word MSB first, changing data on the non-sampling SCK edge.
  always @(negedge clk) begin
    int sl_idx;
    if (rxvalid) begin rv_cnt++; rx_q.push_back(rxdata); end
    if (spi_cs_n == 3'b110) cs0_cnt++;
    if (spi_cs_n != 3'b111) cs_any_cnt++;
    if (busy) busy_cnt++;
    if (prev_cs0 && !spi_cs_n[0]) cs_falls++;
    prev_cs0 = spi_cs_n[0];
    sl_e = spi_cs_n[0] ? 0 : sl_e + int'(spi_sck != sl_sck);
    sl_sck = spi_sck;
    sl_idx = cpha ? (sl_e == 0 ? 0 : (sl_e - 1) >> 1) : sl_e >> 1;
    sl_bit = sl_word[7 - (sl_idx > 7 ? 7 : sl_idx)];
  end

  always @(posedge spi_sck) mosi_cap = {mosi_cap[6:0], spi_mosi};

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] w, input bit keep);
    int n = 0;
    txdata = w;
    txstart = 1'b1;
    while (!txready && n < 2000) begin @(negedge clk); n++; end
    chk("send_accept", 32'(txready), 32'd1);
    @(negedge clk);
    if (!keep) txstart = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int rv0, cs0, bz0, any0, fl0, q0;
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_cs_n", 32'(spi_cs_n), 32'h7);
    chk("rst_rxvalid", 32'(rxvalid), 32'd0);
    chk("rst_busy_txready", 32'({busy, txready}), 32'b01);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, div 0, loopback 0xA5
    rv0 = rv_cnt; cs0 = cs0_cnt; bz0 = busy_cnt;
    send(8'hA5, 0);
    chk("lat_txready_low", 32'(txready), 32'd0);
    chk("lat_cs_still_high", 32'(spi_cs_n), 32'h7);
    @(negedge clk);
    chk("lat_cs_low", 32'(spi_cs_n), 32'h6);
    chk("lat_first_mosi", 32'(spi_mosi), 32'd1);
    wait_idle("idle_a5");
    chk("a5_rxdata", 32'(rxdata), 32'hA5);
    chk("a5_rxvalid_pulses", 32'(rv_cnt - rv0), 32'd1);
    chk("a5_mosi_bits", 32'(mosi_cap), 32'hA5);
    // SETUP + 16 SHIFT half-periods + HOLD with CS low; GAP raises CS
    chk("a5_cs_low_cycles", 32'(cs0_cnt - cs0), 32'd18);
    // one holding-register cycle plus the 19-cycle word frame
    chk("a5_busy_cycles", 32'(busy_cnt - bz0), 32'd20);

    // All four modes against the slave model, div 3
    loop = 1'b0; div = 8'd3;
    for (int m = 0; m < 4; m++) begin
      cpol = m[1]; cpha = m[0];
      repeat (2) @(negedge clk);
      chk($sformatf("mode%0d_sck_idle", m), 32'(spi_sck), 32'(cpol));
      send(8'h5A, 0);
      wait_idle($sformatf("idle_mode%0d", m));
      chk($sformatf("mode%0d_rxdata", m), 32'(rxdata), 32'h3C);
    end
    cpol = 1'b0; cpha = 1'b0; loop = 1'b1; div = 8'd1;
    repeat (2) @(negedge clk);

    // Two chained words with cs_hold
    cs_hold = 1'b1;
    rv0 = rv_cnt; cs0 = cs0_cnt; fl0 = cs_falls; q0 = rx_q.size();
    send(8'h12, 0);
    send(8'h34, 0);
    wait_idle("idle_chain");
    chk("chain_cs_falls", 32'(cs_falls - fl0), 32'd1);
    chk("chain_cs_low_cycles", 32'(cs0_cnt - cs0), 32'd70);
    chk("chain_rxvalid_pulses", 32'(rv_cnt - rv0), 32'd2);
    chk("chain_rx0", 32'(rx_q[q0]), 32'h12);
    chk("chain_rx1", 32'(rx_q[q0+1]), 32'h34);
    cs_hold = 1'b0; div = 8'd0;

    // txstart held while the holding register is full
    q0 = rx_q.size();
    send(8'h11, 0);
    send(8'h22, 1);
    txdata = 8'h33;
    repeat (5) @(negedge clk);
    chk("held_txready_low", 32'(txready), 32'd0);
    send(8'h33, 0);
    wait_idle("idle_held");
    chk("held_count", 32'(rx_q.size() - q0), 32'd3);
    chk("held_rx0", 32'(rx_q[q0]), 32'h11);
    chk("held_rx1", 32'(rx_q[q0+1]), 32'h22);
    chk("held_rx2", 32'(rx_q[q0+2]), 32'h33);

    // LSB first
    lsb_first = 1'b1;
    send(8'h01, 0);
    @(negedge clk);
    chk("lsb_first_mosi", 32'(spi_mosi), 32'd1);
    wait_idle("idle_lsb");
    chk("lsb_rxdata", 32'(rxdata), 32'h01);
    lsb_first = 1'b0;

    // Out-of-range chip select
    cs_sel = 2'd3;
    rv0 = rv_cnt; any0 = cs_any_cnt;
    send(8'h5A, 0);
    wait_idle("idle_oor");
    chk("oor_no_cs", 32'(cs_any_cnt - any0), 32'd0);
    chk("oor_rxvalid", 32'(rv_cnt - rv0), 32'd1);
    chk("oor_rxdata", 32'(rxdata), 32'h5A);
    cs_sel = 2'd0;

    // Asynchronous reset in the middle of SHIFT
    div = 8'd3;
    send(8'hFF, 0);
    repeat (20) @(negedge clk);
    chk("mid_cs_low", 32'(spi_cs_n), 32'h6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sck", 32'(spi_sck), 32'd0);
    chk("arst_mosi", 32'(spi_mosi), 32'd0);
    chk("arst_cs_n", 32'(spi_cs_n), 32'h7);
    chk("arst_rxdata", 32'(rxdata), 32'h0);
    chk("arst_busy_txready", 32'({busy, txready}), 32'b01);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rv0 = rv_cnt;
    send(8'hC3, 0);
    wait_idle("idle_after_rst");
    chk("after_rst_rxdata", 32'(rxdata), 32'hC3);
    chk("after_rst_rxvalid", 32'(rv_cnt - rv0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
